phys_reg_freelist: RTL and testbench
====================================

# phys_reg_freelist

R10K-style physical register free list that arbitrates the pool of physical tags among the `N` dispatch slots. Each cycle it offers up to `N` one-hot grants from a registered speculative free bitmap, consumes the granted tags the dispatch stage actually uses, and reclaims each retiring instruction's previous mapping (Told). It also keeps an architectural free bitmap updated at retire, so that a pipeline flush can restore the speculative list in one cycle. It sits between dispatch (allocation) and the ROB retire port (reclaim and recovery).

## Interface
Parameters:
- `N`, default `` `N `` (3): dispatch and retire width.
- `PHYS_REG_SZ`, default `` `PHYS_REG_SZ_R10K `` (64): number of physical tags.
- `ARCH_REG_SZ`, default `` `ARCH_REG_SZ `` (32): tags 0..ARCH_REG_SZ-1 hold the reset mapping.

Ports:
- `clock` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `alloc_req` in N: slot i consumes `granted_regs[i]` at the next edge.
- `granted_regs` out N×PHYS_REG_SZ: one-hot offer per slot; all-zero means no tag available.
- `free_slots` out $clog2(PHYS_REG_SZ+1): registered popcount of the speculative free bitmap.
- `retire_valid` in N: slot i retires an instruction that wrote a destination.
- `retire_told` in N×PHYS_TAG: tag to reclaim.
- `retire_tnew` in N×PHYS_TAG: tag becoming architectural.
- `flush` in 1: mispredict or exception recovery.
- `fl_error` out 1: sticky protocol-error flag (see Configuration).

## Operation
- State:
  - `spec_free[PHYS_REG_SZ]`
  - `arch_free[PHYS_REG_SZ]`
  - `free_cnt` register
- Reset (asynchronous, `reset`=0):
  - Bits 0..ARCH_REG_SZ-1 clear and bits ARCH_REG_SZ..PHYS_REG_SZ-1 set, in both bitmaps.
  - `free_slots` = PHYS_REG_SZ-ARCH_REG_SZ.
  - `fl_error` = 0.
  - `granted_regs` reflects the reset bitmap: slot i is offered tag ARCH_REG_SZ+i.
- Grant selection, purely combinational from `spec_free` with no path from `alloc_req`:
  - Slot i is offered the (i+1)-th lowest-indexed set bit.
  - If fewer than i+1 bits are set, slot i is offered all-zero.
  - Offers are independent of which slots request. An unrequested offer stays free.
- Allocation: at the edge, `spec_free` clears the bit of each requested slot with a nonzero grant.
  - A request on an all-zero grant is dropped.
  - `alloc_req` may be non-contiguous.
- Reclaim: at the edge, `spec_free` and `arch_free` both set bit `retire_told[i]` for each valid retire slot.
- Commit: `arch_free` clears bit `retire_tnew[i]` for each valid retire slot.
- Tag 0 is never reclaimed or committed; retire fields equal to 0 are ignored.
- Flush: `spec_free` is loaded with the next value of `arch_free`, which includes this cycle's retires. All `alloc_req` in that cycle are discarded.
- Precedence within one edge:
  1. reset
  2. flush
  3. allocate + reclaim, applied together; their bit sets are disjoint by construction
- `free_cnt` is the popcount of next-state `spec_free`, computed at full width with no saturation.

## Timing
- Grant offer latency: 0 cycles from state.
- Allocation takes effect at the next rising edge.
- A reclaimed tag becomes grantable 1 cycle after its retire edge, never in the same cycle.
- `free_slots` updates together with `spec_free` and always equals its popcount.
- Flush recovery takes 1 cycle: grants in the cycle after flush derive from the restored bitmap.
- Full pool (`free_slots`=PHYS_REG_SZ-1, all but tag 0): offers are the lowest N free tags.
- Empty pool: all offers are zero. Requests are ignored, and the dispatch stage stalls on `free_slots`.
- A reset asserted mid-operation overrides everything immediately. Release is synchronous to the next `clock` edge.

## Configuration
- `FREELIST_CHECK_EN` defined: `fl_error` sets and stays set until reset on any of:
  - an allocation request on an all-zero grant;
  - a reclaim of a tag already set in `spec_free` (double free);
  - a commit of a tag already clear in `arch_free`.
  
  A checking failure never alters bitmap behaviour.
- `FREELIST_CHECK_EN` undefined: checking logic is absent and `fl_error` is tied to 0.

## Test plan
- Reset, then `alloc_req`=3'b111 for one cycle -> grants of tags 32, 33, 34 in that cycle; `free_slots` 32 -> 29; next offers are 35, 36, 37.
- `alloc_req`=3'b101 -> tags 32 and 34 consumed; next cycle offers are 33, 35, 36.
- Drain to `free_slots`=1, then request 3'b111 -> only slot 0 is granted; `free_slots` becomes 0; the next cycle has all-zero offers. With the check macro, `fl_error`=1.
- Allocate 32, then retire with told=5 and tnew=32 -> tag 5 is offered as slot 0 one cycle later, not earlier; `arch_free[32]`=0.
- Allocate 32..37 over 2 cycles, then flush in the same cycle as a retire of told=7, tnew=32 -> next cycle `spec_free` = reset pattern with bit 32 clear and bit 7 set; `free_slots`=32; offers are 7, 33, 34.
- Retire with told=0 -> no change. Retire told=40 while 40 is already free -> bitmap unchanged; `fl_error`=1 with the macro, 0 without.

Source files
------------

// File: rtl/phys_reg_freelist.sv
// R10K-style physical register free list: speculative + architectural free bitmaps,
// N-wide lowest-first grant offers, retire reclaim, one-cycle flush recovery.
// Optional protocol checking is enabled by defining FREELIST_CHECK_EN.
`ifndef N
`define N 3
`endif
`ifndef PHYS_REG_SZ_R10K
`define PHYS_REG_SZ_R10K 64
`endif
`ifndef ARCH_REG_SZ
`define ARCH_REG_SZ 32
`endif

module phys_reg_freelist #(
  parameter int N           = `N,
  parameter int PHYS_REG_SZ = `PHYS_REG_SZ_R10K,
  parameter int ARCH_REG_SZ = `ARCH_REG_SZ,
  parameter int PHYS_TAG    = $clog2(PHYS_REG_SZ),
  parameter int CNT_W       = $clog2(PHYS_REG_SZ+1)
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [N-1:0]                        alloc_req,
  output logic [N-1:0][PHYS_REG_SZ-1:0]       granted_regs,
  output logic [CNT_W-1:0]                    free_slots,
  input  logic [N-1:0]                        retire_valid,
  input  logic [N-1:0][PHYS_TAG-1:0]          retire_told,
  input  logic [N-1:0][PHYS_TAG-1:0]          retire_tnew,
  input  logic                                flush,
  output logic                                fl_error
);

  localparam logic [PHYS_REG_SZ-1:0] RST_MAP = {PHYS_REG_SZ{1'b1}} << ARCH_REG_SZ;

  logic [PHYS_REG_SZ-1:0] r_spec_free, r_arch_free;
  logic [CNT_W-1:0]       r_free_cnt;

  logic [N-1:0][PHYS_REG_SZ-1:0] w_avail;
  logic [PHYS_REG_SZ-1:0] w_alloc_clr, w_reclaim, w_commit;
  logic [PHYS_REG_SZ-1:0] w_spec_nxt, w_arch_nxt;
  logic [CNT_W-1:0]       w_cnt_nxt;

  // Each slot takes the lowest set bit of what the slots before it left over.
  assign w_avail[0] = r_spec_free;
  for (genvar i = 0; i < N; i++) begin : g_slot
    assign granted_regs[i] = w_avail[i] & (~w_avail[i] + PHYS_REG_SZ'(1));
    if (i < N-1) begin : g_next
      assign w_avail[i+1] = w_avail[i] & ~granted_regs[i];
    end
  end

  always_comb begin
    w_alloc_clr = '0;
    w_reclaim   = '0;
    w_commit    = '0;
    for (int i = 0; i < N; i++) begin
      if (alloc_req[i]) w_alloc_clr = w_alloc_clr | granted_regs[i];
      if (retire_valid[i] && retire_told[i] != '0) w_reclaim[retire_told[i]] = 1'b1;
      if (retire_valid[i] && retire_tnew[i] != '0) w_commit[retire_tnew[i]]  = 1'b1;
    end
    w_arch_nxt = (r_arch_free | w_reclaim) & ~w_commit;
    // Flush restores from the post-retire architectural view; allocations are dropped.
    w_spec_nxt = flush ? w_arch_nxt : ((r_spec_free & ~w_alloc_clr) | w_reclaim);
    w_cnt_nxt  = '0;
    for (int k = 0; k < PHYS_REG_SZ; k++) w_cnt_nxt = w_cnt_nxt + CNT_W'(w_spec_nxt[k]);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_spec_free <= RST_MAP;
      r_arch_free <= RST_MAP;
      r_free_cnt  <= CNT_W'(PHYS_REG_SZ - ARCH_REG_SZ);
    end else begin
      r_spec_free <= w_spec_nxt;
      r_arch_free <= w_arch_nxt;
      r_free_cnt  <= w_cnt_nxt;
    end
  end

  assign free_slots = r_free_cnt;

`ifdef FREELIST_CHECK_EN
  logic w_zero_req, w_err_now, r_fl_error;

  always_comb begin
    w_zero_req = 1'b0;
    for (int i = 0; i < N; i++)
      if (alloc_req[i] && granted_regs[i] == '0) w_zero_req = 1'b1;
    w_err_now = (w_zero_req && !flush) | (|(w_reclaim & r_spec_free)) |
                (|(w_commit & ~r_arch_free));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)         r_fl_error <= 1'b0;
    else if (w_err_now) r_fl_error <= 1'b1;
  end

  assign fl_error = r_fl_error;
`else
  assign fl_error = 1'b0;
`endif

endmodule

// File: tb/tb_phys_reg_freelist.sv
// Directed bench for phys_reg_freelist: a bitmap model pushes expected offers/count/error
// per step into a queue, popped and compared after each edge, plus fixed-value checks.
module tb_phys_reg_freelist;
  localparam int NS = 3;
  localparam int PS = 64;
  localparam int TW = 6;
  localparam logic [PS-1:0] RST = {{32{1'b1}}, 32'h0};

  logic                  clock = 1'b0;
  logic                  reset;
  logic [NS-1:0]         alloc_req;
  logic [NS-1:0][PS-1:0] granted_regs;
  logic [6:0]            free_slots;
  logic [NS-1:0]         retire_valid;
  logic [NS-1:0][TW-1:0] retire_told, retire_tnew;
  logic                  flush;
  logic                  fl_error;

  phys_reg_freelist dut (
    .clock(clock), .reset(reset), .alloc_req(alloc_req), .granted_regs(granted_regs),
    .free_slots(free_slots), .retire_valid(retire_valid), .retire_told(retire_told),
    .retire_tnew(retire_tnew), .flush(flush), .fl_error(fl_error)
  );

  always #5 clock = ~clock;

  typedef struct {
    string tag;
    int    o0, o1, o2, fs;
    logic  err;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  logic [PS-1:0] m_spec, m_arch;
  logic m_err;

  function automatic int gidx(input logic [PS-1:0] v);
    int r;
    r = -1;
    if ($countones(v) > 1) return -2;
    for (int k = 0; k < PS; k++) if (v[k]) r = k;
    return r;
  endfunction

  function automatic int nth_free(input logic [PS-1:0] m, input int n);
    int seen;
    seen = 0;
    for (int k = 0; k < PS; k++)
      if (m[k]) begin
        if (seen == n) return k;
        seen++;
      end
    return -1;
  endfunction

  function automatic logic exp_err(input logic e);
`ifdef FREELIST_CHECK_EN
    return e;
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic chk_offers(input string tag, input int e0, input int e1, input int e2);
    chk({tag, "_off0"}, gidx(granted_regs[0]), e0);
    chk({tag, "_off1"}, gidx(granted_regs[1]), e1);
    chk({tag, "_off2"}, gidx(granted_regs[2]), e2);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b0;
    m_spec = RST;
    m_arch = RST;
    m_err = 1'b0;
    #2;
    chk({tag, "_rst_fs"}, int'(free_slots), 32);
    chk({tag, "_rst_err"}, int'(fl_error), 0);
    chk_offers({tag, "_rst"}, 32, 33, 34);
    reset = 1'b1;
  endtask

  task automatic drive(input string tag, input logic [2:0] a, input logic [2:0] rv,
                       input int t0, input int n0, input logic fl);
    int off[3];
    logic [PS-1:0] rc, cm, nspec, narch;
    exp_t e;
    exp_t got;
    for (int i = 0; i < 3; i++) off[i] = nth_free(m_spec, i);
    rc = '0;
    cm = '0;
    // only slot 0 carries retire tags in these scenarios
    if (rv[0] && t0 != 0) rc[t0] = 1'b1;
    if (rv[0] && n0 != 0) cm[n0] = 1'b1;
    if (|(rc & m_spec)) m_err = 1'b1;
    if (|(cm & ~m_arch)) m_err = 1'b1;
    narch = (m_arch | rc) & ~cm;
    if (fl) nspec = narch;
    else begin
      nspec = m_spec;
      for (int i = 0; i < 3; i++)
        if (a[i]) begin
          if (off[i] < 0) m_err = 1'b1;
          else nspec[off[i]] = 1'b0;
        end
      nspec = nspec | rc;
    end
    m_spec = nspec;
    m_arch = narch;
    e.tag = tag;
    e.o0 = nth_free(nspec, 0);
    e.o1 = nth_free(nspec, 1);
    e.o2 = nth_free(nspec, 2);
    e.fs = $countones(nspec);
    e.err = exp_err(m_err);
    sb.push_back(e);

    alloc_req = a;
    retire_valid = rv;
    retire_told = '0;
    retire_tnew = '0;
    retire_told[0] = TW'(t0);
    retire_tnew[0] = TW'(n0);
    flush = fl;
    @(posedge clock);
    #1;
    alloc_req = '0;
    retire_valid = '0;
    flush = 1'b0;
    got = sb.pop_front();
    chk_offers(got.tag, got.o0, got.o1, got.o2);
    chk({got.tag, "_fs"}, int'(free_slots), got.fs);
    chk({got.tag, "_err"}, int'(fl_error), int'(got.err));
  endtask

  initial begin
    reset = 1'b0;
    alloc_req = '0;
    retire_valid = '0;
    retire_told = '0;
    retire_tnew = '0;
    flush = 1'b0;
    #12;

    // A: full-width allocation from reset
    do_reset("A");
    drive("A_alloc111", 3'b111, 3'b000, 0, 0, 1'b0);
    chk_offers("A_fixed", 35, 36, 37);
    chk("A_fixed_fs", int'(free_slots), 29);

    // B: sparse request, then drain to empty
    do_reset("B");
    drive("B_alloc101", 3'b101, 3'b000, 0, 0, 1'b0);
    chk_offers("B_fixed", 33, 35, 36);
    for (int s = 0; s < 9; s++) drive("B_drain", 3'b111, 3'b000, 0, 0, 1'b0);
    drive("B_alloc011", 3'b011, 3'b000, 0, 0, 1'b0);
    chk("B_fs1", int'(free_slots), 1);
    drive("B_last", 3'b111, 3'b000, 0, 0, 1'b0);
    chk("B_empty_fs", int'(free_slots), 0);
    chk_offers("B_empty", -1, -1, -1);
    chk("B_empty_err", int'(fl_error), int'(exp_err(1'b1)));
    drive("B_idle", 3'b000, 3'b000, 0, 0, 1'b0);

    // C: reclaim visible one cycle later; commit clears arch bit 32
    do_reset("C");
    drive("C_alloc", 3'b001, 3'b000, 0, 0, 1'b0);
    drive("C_retire", 3'b000, 3'b001, 5, 32, 1'b0);
    chk_offers("C_fixed", 5, 33, 34);
    chk("C_fixed_fs", int'(free_slots), 32);
    drive("C_flush", 3'b000, 3'b000, 0, 0, 1'b1);
    chk_offers("C_arch", 5, 33, 34);

    // D: flush coincident with retire restores arch view, drops allocation
    do_reset("D");
    drive("D_a1", 3'b111, 3'b000, 0, 0, 1'b0);
    drive("D_a2", 3'b111, 3'b000, 0, 0, 1'b0);
    drive("D_flush", 3'b111, 3'b001, 7, 32, 1'b1);
    chk_offers("D_fixed", 7, 33, 34);
    chk("D_fixed_fs", int'(free_slots), 32);

    // E: tag-0 retire ignored; double free leaves bitmap alone
    do_reset("E");
    drive("E_told0", 3'b000, 3'b001, 0, 0, 1'b0);
    chk_offers("E_fixed0", 32, 33, 34);
    chk("E_fixed0_err", int'(fl_error), 0);
    drive("E_dbl", 3'b000, 3'b001, 40, 0, 1'b0);
    chk_offers("E_fixed_dbl", 32, 33, 34);
    chk("E_fixed_dbl_fs", int'(free_slots), 32);
    chk("E_fixed_dbl_err", int'(fl_error), int'(exp_err(1'b1)));

    // F: asynchronous reset mid-operation
    drive("F_alloc", 3'b111, 3'b000, 0, 0, 1'b0);
    do_reset("F");
    drive("F_after", 3'b010, 3'b000, 0, 0, 1'b0);

    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
